// File: rtl/multi_port_mem_arbiter_pkg.sv
// Shared types and sizing helpers for the multi-port memory arbiter.
package arbiter_types;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } arb_state_t;

  // Byte-offset bits inside one cache line.
  function automatic int unsigned line_offset_w(int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_idx_w(int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_port_mem_arbiter_if.sv
// Client-side and pmem-side bus of the memory arbiter; slave is the arbiter's view.
interface multi_port_mem_arbiter_if #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
);

  logic [NUM_CH-1:0]             ch_read;
  logic [NUM_CH-1:0]             ch_write;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]             ch_rdata;
  logic [NUM_CH-1:0]             ch_resp;

  logic                          pmem_read;
  logic                          pmem_write;
  logic [ADDR_W-1:0]             pmem_addr;
  logic [BURST_W-1:0]            pmem_wdata;
  logic [BURST_W-1:0]            pmem_rdata;
  logic                          pmem_resp;

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, pmem_rdata, pmem_resp,
    output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, pmem_rdata, pmem_resp,
    input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/multi_port_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after `last`, wrapping.
module rr_pick #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    // Scan last+1 .. last+NUM_CH so `last` itself has lowest priority.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = (32'(last) + i) % NUM_CH;
      if (!valid && req[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_arbiter.sv
// Round-robin arbiter between NUM_CH cache-line clients and one pmem burst port;
// serves one line at a time and splits each line into BEATS pmem beats.
module multi_port_mem_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_port_mem_arbiter_if.slave   bus
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W = ch_idx_w(NUM_CH);
  localparam int unsigned OFF_W = line_offset_w(LINE_W);

  arb_state_t                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               grant_q, grant_d;
  logic [IDX_W-1:0]               last_q, last_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [BEATS-1:0][BURST_W-1:0]  line_q, line_d;
  logic [BURST_W-1:0]             wdata_q, wdata_d;
  logic                           read_q, read_d;
  logic                           write_q, write_d;
  logic [NUM_CH-1:0]              resp_q, resp_d;

  logic [IDX_W-1:0]               pick_grant;
  logic                           pick_valid;
  logic                           last_beat;
  logic [CNT_W-1:0]               cnt_nxt;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req   (bus.ch_read | bus.ch_write),
    .last  (last_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign last_beat = bus.pmem_resp && (cnt_q == CNT_W'(BEATS - 1));
  assign cnt_nxt   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          addr_d  = bus.ch_addr[pick_grant];
          addr_d[OFF_W-1:0] = '0;
          line_d  = bus.ch_wdata[pick_grant];
          wdata_d = bus.ch_wdata[pick_grant][BURST_W-1:0];
          cnt_d   = '0;
          // A client raising both strobes is in error; the write is honoured.
          if (bus.ch_write[pick_grant]) begin
            state_d = StWrite;
            write_d = 1'b1;
          end else begin
            state_d = StRead;
            read_d  = 1'b1;
          end
        end
      end

      StRead: begin
        if (bus.pmem_resp) begin
          line_d[cnt_q] = bus.pmem_rdata;
          if (last_beat) begin
            state_d = StDone;
            read_d  = 1'b0;
            resp_d  = NUM_CH'(1) << grant_q;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end

      StWrite: begin
        if (bus.pmem_resp) begin
          if (last_beat) begin
            state_d = StDone;
            write_d = 1'b0;
            resp_d  = NUM_CH'(1) << grant_q;
          end else begin
            cnt_d   = cnt_nxt;
            wdata_d = line_q[cnt_nxt];
          end
        end
      end

      StDone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_CH - 1);
      addr_q  <= '0;
      line_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.pmem_read  = read_q;
  assign bus.pmem_write = write_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.ch_rdata   = line_q;
  assign bus.ch_resp    = resp_q;

endmodule

// File: tb/tb_multi_port_mem_arbiter.sv
// Directed bench for multi_port_mem_arbiter: a 2-channel and a 4-channel instance.
module tb_multi_port_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  multi_port_mem_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .BURST_W(64)) bus ();
  multi_port_mem_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .LINE_W(256), .BURST_W(64)) bus4 ();

  multi_port_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .BURST_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multi_port_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .LINE_W(256), .BURST_W(64)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ch_read = '0;  bus.ch_write = '0;  bus.ch_addr = '0;  bus.ch_wdata = '0;
    bus.pmem_rdata = '0;  bus.pmem_resp = 1'b0;
    bus4.ch_read = '0; bus4.ch_write = '0; bus4.ch_addr = '0; bus4.ch_wdata = '0;
    bus4.pmem_rdata = '0; bus4.pmem_resp = 1'b0;
    #1 rst = 1'b0;
    tick();
    n_checks++; if (bus.pmem_read !== 1'b0) $display("FAIL reset_read got %b want 0", bus.pmem_read); else n_pass++;
    n_checks++; if (bus.pmem_write !== 1'b0) $display("FAIL reset_write got %b want 0", bus.pmem_write); else n_pass++;
    n_checks++; if (bus.ch_resp !== 2'b00) $display("FAIL reset_resp got %b want 00", bus.ch_resp); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.pmem_addr); else n_pass++;
    n_checks++; if (bus.pmem_wdata !== 64'h0) $display("FAIL reset_wdata got %h want 0", bus.pmem_wdata); else n_pass++;
    n_checks++; if (bus.ch_rdata !== 256'h0) $display("FAIL reset_rdata got %h want 0", bus.ch_rdata); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    logic [63:0]  beats [4];
    logic [255:0] line;
    beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
    line = {beats[3], beats[2], beats[1], beats[0]};
    bus.ch_addr[0] = 32'h0000_0064;
    bus.ch_read[0] = 1'b1;
    bus.pmem_resp  = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (cyc <= 4) bus.pmem_rdata = beats[cyc-1];
      if (cyc == 1) begin
        bus.ch_addr[0] = 32'hFFFF_FFFF;
        n_checks++; if (bus.pmem_write !== 1'b0) $display("FAIL rd_no_write got %b want 0", bus.pmem_write); else n_pass++;
      end
      if (cyc == 1 || cyc == 4) begin
        n_checks++; if (bus.pmem_addr !== 32'h0000_0060) $display("FAIL rd_addr c%0d got %h want 00000060", cyc, bus.pmem_addr); else n_pass++;
      end
      n_checks++; if (bus.pmem_read !== (cyc <= 4)) $display("FAIL rd_strobe c%0d got %b want %b", cyc, bus.pmem_read, (cyc <= 4)); else n_pass++;
      n_checks++; if (bus.ch_resp !== ((cyc == 5) ? 2'b01 : 2'b00)) $display("FAIL rd_resp c%0d got %b", cyc, bus.ch_resp); else n_pass++;
      if (cyc == 5) begin
        n_checks++; if (bus.ch_rdata !== line) $display("FAIL rd_line got %h want %h", bus.ch_rdata, line); else n_pass++;
        bus.ch_read[0] = 1'b0;
      end
    end
    bus.pmem_resp = 1'b0;
  endtask

  task automatic test_write_delayed();
    logic [63:0] dw [4];
    int b = 0, d = 0, resp_cnt = 0;
    logic prev_resp = 1'b0, seen = 1'b0;
    dw[0] = 64'hD0D0_0000_0000_00D0; dw[1] = 64'hD1D1_0000_0000_00D1;
    dw[2] = 64'hD2D2_0000_0000_00D2; dw[3] = 64'hD3D3_0000_0000_00D3;
    bus.ch_wdata[1] = {dw[3], dw[2], dw[1], dw[0]};
    bus.ch_addr[1]  = 32'h8000_0020;
    bus.ch_write[1] = 1'b1;
    bus.pmem_resp   = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (prev_resp) b++;
      if (cyc == 1) begin
        n_checks++; if (bus.pmem_addr !== 32'h8000_0020) $display("FAIL wr_addr got %h want 80000020", bus.pmem_addr); else n_pass++;
      end
      if (cyc == 2) bus.ch_wdata[1] = '1;
      n_checks++; if (bus.pmem_write !== (b < 4)) $display("FAIL wr_strobe c%0d got %b want %b", cyc, bus.pmem_write, (b < 4)); else n_pass++;
      if (b < 4) begin
        n_checks++; if (bus.pmem_wdata !== dw[b]) $display("FAIL wr_beat%0d c%0d got %h want %h", b, cyc, bus.pmem_wdata, dw[b]); else n_pass++;
      end
      n_checks++; if (bus.ch_resp !== ((b == 4 && !seen) ? 2'b10 : 2'b00)) $display("FAIL wr_resp c%0d got %b", cyc, bus.ch_resp); else n_pass++;
      if (bus.ch_resp != 2'b00) resp_cnt++;
      if (b == 4 && !seen) begin
        seen = 1'b1;
        bus.ch_write[1] = 1'b0;
      end
      if (b < 4 && d == 3) begin
        bus.pmem_resp = 1'b1;
        d = 0;
      end else begin
        bus.pmem_resp = 1'b0;
        if (b < 4) d++;
      end
      prev_resp = bus.pmem_resp;
    end
    n_checks++; if (resp_cnt != 1) $display("FAIL wr_resp_count got %0d want 1", resp_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n = 0, last_cyc = 0;
    logic bubble = 1'b0;
    logic [1:0] want;
    #1 rst = 1'b0;
    tick();
    bus.ch_addr[0] = 32'h0000_0100; bus.ch_read[0]  = 1'b1;
    bus.ch_addr[1] = 32'h0000_0200; bus.ch_write[1] = 1'b1;
    bus.pmem_resp  = 1'b1;
    rst = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (bus.ch_resp != 2'b00) begin
        want = (n % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++; if (bus.ch_resp !== want) $display("FAIL b2b_grant%0d got %b want %b", n, bus.ch_resp, want); else n_pass++;
        if (n > 0) begin
          n_checks++; if (cyc - last_cyc != 6) $display("FAIL b2b_gap%0d got %0d want 6", n, cyc - last_cyc); else n_pass++;
        end
        last_cyc = cyc;
        n++;
        if (bus.ch_resp[0]) bus.ch_read[0] = 1'b0; else bus.ch_write[1] = 1'b0;
        if (n == 4) begin
          bus.ch_read[0] = 1'b0; bus.ch_write[1] = 1'b0;
          break;
        end
        bubble = 1'b1;
      end else if (bubble) begin
        n_checks++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) $display("FAIL b2b_bubble c%0d got %b want 00", cyc, {bus.pmem_read, bus.pmem_write}); else n_pass++;
        bus.ch_read[0] = 1'b1; bus.ch_write[1] = 1'b1;
        bubble = 1'b0;
      end
    end
    n_checks++; if (n != 4) $display("FAIL b2b_count got %0d want 4", n); else n_pass++;
    tick();
    bus.pmem_resp = 1'b0;
  endtask

  task automatic test_four_ch();
    logic [3:0] order [4];
    int n = 0;
    logic got = 1'b0;
    order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b0010; order[3] = 4'b0100;
    bus4.pmem_resp = 1'b1;
    bus4.ch_read   = 4'b0100;
    for (int cyc = 1; cyc <= 10 && !got; cyc++) begin
      tick();
      if (bus4.ch_resp != 4'b0000) begin
        got = 1'b1;
        n_checks++; if (bus4.ch_resp !== 4'b0100) $display("FAIL rr4_first got %b want 0100", bus4.ch_resp); else n_pass++;
        bus4.ch_read = 4'b0000;
      end
    end
    n_checks++; if (!got) $display("FAIL rr4_first_timeout got none want 0100"); else n_pass++;
    tick();
    bus4.ch_read = 4'b1111;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      tick();
      if (bus4.ch_resp != 4'b0000) begin
        n_checks++; if (bus4.ch_resp !== order[n]) $display("FAIL rr4_order%0d got %b want %b", n, bus4.ch_resp, order[n]); else n_pass++;
        bus4.ch_read = bus4.ch_read & ~bus4.ch_resp;
        n++;
      end
    end
    n_checks++; if (n != 4) $display("FAIL rr4_count got %0d want 4", n); else n_pass++;
    bus4.ch_read   = 4'b0000;
    bus4.pmem_resp = 1'b0;
  endtask

  task automatic test_spurious_resp();
    logic [63:0]  beats [4];
    logic [255:0] line;
    int b = 0, strobes = 0;
    logic done = 1'b0;
    beats[0] = 64'h0123_4567_89AB_CDEF; beats[1] = 64'h1000_0000_0000_0001;
    beats[2] = 64'h2000_0000_0000_0002; beats[3] = 64'h3000_0000_0000_0003;
    line = {beats[3], beats[2], beats[1], beats[0]};
    bus.pmem_resp = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      n_checks++; if ({bus.pmem_read, bus.pmem_write, bus.ch_resp} !== 4'b0000) $display("FAIL idle_resp c%0d got %b want 0000", cyc, {bus.pmem_read, bus.pmem_write, bus.ch_resp}); else n_pass++;
    end
    bus.ch_addr[0] = 32'h0000_01C7;
    bus.ch_read[0] = 1'b1;
    for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
      tick();
      if (bus.pmem_read) begin
        strobes++;
        if (b < 4) bus.pmem_rdata = beats[b];
        b++;
      end
      if (bus.ch_resp != 2'b00) begin
        done = 1'b1;
        n_checks++; if (bus.ch_rdata !== line) $display("FAIL idle_line got %h want %h", bus.ch_rdata, line); else n_pass++;
        bus.ch_read[0] = 1'b0;
      end
      if (cyc == 1) begin
        n_checks++; if (bus.pmem_addr !== 32'h0000_01C0) $display("FAIL idle_addr got %h want 000001c0", bus.pmem_addr); else n_pass++;
      end
    end
    n_checks++; if (strobes != 4) $display("FAIL idle_beats got %0d want 4", strobes); else n_pass++;
    bus.pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0]  beats [4];
    logic [255:0] line;
    int b = 0, strobes = 0;
    logic done = 1'b0;
    beats[0] = 64'hAAAA_0000_0000_000A; beats[1] = 64'hBBBB_0000_0000_000B;
    beats[2] = 64'hCCCC_0000_0000_000C; beats[3] = 64'hDDDD_0000_0000_000D;
    line = {beats[3], beats[2], beats[1], beats[0]};
    bus.ch_addr[1]  = 32'h0000_0040;
    bus.ch_read[1]  = 1'b1;
    bus.pmem_resp   = 1'b1;
    bus.pmem_rdata  = 64'hEEEE_EEEE_EEEE_EEEE;
    tick(); tick(); tick();
    n_checks++; if (bus.pmem_read !== 1'b1) $display("FAIL mid_strobe_before got %b want 1", bus.pmem_read); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.pmem_read !== 1'b0) $display("FAIL mid_strobe_drop got %b want 0", bus.pmem_read); else n_pass++;
    tick();
    n_checks++; if (bus.ch_resp !== 2'b00) $display("FAIL mid_no_resp got %b want 00", bus.ch_resp); else n_pass++;
    rst = 1'b1;
    for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
      tick();
      if (bus.pmem_read) begin
        strobes++;
        if (b < 4) bus.pmem_rdata = beats[b];
        b++;
      end
      if (bus.ch_resp != 2'b00) begin
        done = 1'b1;
        n_checks++; if (bus.ch_resp !== 2'b10) $display("FAIL mid_resp got %b want 10", bus.ch_resp); else n_pass++;
        n_checks++; if (bus.ch_rdata !== line) $display("FAIL mid_line got %h want %h", bus.ch_rdata, line); else n_pass++;
        bus.ch_read[1] = 1'b0;
      end
    end
    n_checks++; if (!done) $display("FAIL mid_timeout got none want resp 10"); else n_pass++;
    n_checks++; if (strobes != 4) $display("FAIL mid_beats got %0d want 4", strobes); else n_pass++;
    bus.pmem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_delayed();
    test_back_to_back();
    test_four_ch();
    test_spurious_resp();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_port_mem_arbiter.md
# multi_port_mem_arbiter

- Parametrised arbiter and burst adaptor between `NUM_CH` cache-line clients (I-cache, D-cache, later prefetch/victim buffers) and the single physical-memory burst port of the mp4 top level.
- Serves one line transaction at a time.
- Picks clients round-robin.
- Converts each `LINE_W` line into `LINE_W/BURST_W` pmem beats.
- Replaces the fixed two-port hookup at the CP2 memory boundary; adding a channel is a parameter change.

## Interface
Parameters:
- `NUM_CH`, 2: number of client channels (≥1); channel 0 = I-cache, 1 = D-cache.
- `ADDR_W`, 32: byte-address width.
- `LINE_W`, 256: cache-line width in bits.
- `BURST_W`, 64: pmem beat width; `BEATS = LINE_W/BURST_W` (integer, power of two).

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk`  in  1  single clock, rising edge.
  - `rst`  in  1  asynchronous, active-low reset.
- Client side:
  - `ch_read`  in  `NUM_CH`  per-channel line read request, level.
  - `ch_write`  in  `NUM_CH`  per-channel line write request, level.
  - `ch_addr`  in  `NUM_CH`×`ADDR_W`  per-channel address.
  - `ch_wdata`  in  `NUM_CH`×`LINE_W`  per-channel write line.
  - `ch_rdata`  out  `LINE_W`  shared read line, valid with `ch_resp`.
  - `ch_resp`  out  `NUM_CH`  one-hot completion pulse.
- pmem side:
  - `pmem_read`  out  1  burst read strobe.
  - `pmem_write`  out  1  burst write strobe.
  - `pmem_addr`  out  `ADDR_W`  line-aligned burst address.
  - `pmem_wdata`  out  `BURST_W`  current write beat.
  - `pmem_rdata`  in  `BURST_W`  read beat.
  - `pmem_resp`  in  1  one beat accepted or returned this cycle.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: channel *c* is requesting if `ch_read[c]|ch_write[c]`.
  - Grant the first requesting channel in order `last+1, last+2, …` modulo `NUM_CH`.
  - Latch the grant index, the line-aligned address (low `log2(LINE_W/8)` bits forced to 0) and `ch_wdata[grant]`.
  - Clear the beat counter.
  - Go to WRITE if `ch_write[grant]`, else READ. Write wins if both strobes are set on one channel; that case is a client protocol error.
- READ: hold `pmem_read`=1 and `pmem_addr`.
  - On each `pmem_resp`, store `pmem_rdata` into line slice [counter] and increment the counter.
  - On the `BEATS`-th resp, go to DONE.
- WRITE: hold `pmem_write`=1; `pmem_wdata` = latched line slice [counter].
  - Increment the counter on each `pmem_resp`.
  - On the `BEATS`-th resp, go to DONE.
- DONE:
  - `ch_resp[grant]`=1 for exactly this cycle; `ch_rdata` = assembled line (READ) or the last buffer contents (WRITE, don't-care).
  - `last` ← grant; go to IDLE.
- `pmem_resp` is ignored in IDLE and DONE.
- The beat counter is `log2(BEATS)` bits wide. The terminal beat is detected at count `BEATS-1` together with resp, so there is no overflow and no wrap.
- Client address and data may change after the grant edge without effect; the latched copies are used.
- Non-granted requests stay pending. No client is starved: worst-case wait is `NUM_CH-1` transactions.

## Timing
- Reset (`rst`=0, asynchronous):
  - Outputs: `pmem_read`, `pmem_write`, `ch_resp` = 0; `pmem_addr`, `pmem_wdata`, `ch_rdata` = 0.
  - Internal: state IDLE, counter 0, `last` = `NUM_CH-1` so channel 0 has first priority.
- Reset mid-burst: strobes drop immediately and the burst is abandoned; no `ch_resp` is issued.
- Clients hold a request until they see `ch_resp`, then deassert it in the next cycle. The IDLE cycle after DONE therefore never re-grants a completed request.
- Minimum latency, request seen at edge E with `pmem_resp` high every cycle:
  - Strobe high in cycles E+1..E+`BEATS`.
  - `ch_resp` in cycle E+`BEATS`+1.
  - Next grant no earlier than E+`BEATS`+2.
- Strobes, `pmem_addr` and `pmem_wdata` are registered and stable for the whole burst; `pmem_wdata` changes only on the edge after a resp.
- Back-to-back transactions have one IDLE bubble.

## Structure
- Shared package `arbiter_types`:
  - state enum `arb_state_t`.
  - `LINE_OFFSET_W` helper function.
  - channel index width function `$clog2(NUM_CH)`, minimum 1.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs: request vector and `last`. Outputs: grant index and valid.
- The line buffer, counter and FSM stay in the top module.

## Test plan
- Reset, then a single I-cache read of 0x0000_0064:
  - `pmem_addr`=0x0000_0060; beats 0x11..,0x22..,0x33..,0x44.. assemble LSB-first.
  - `ch_resp`=01 in cycle E+5; `ch_rdata` matches.
- D-cache write of 0x8000_0020 with line {D3,D2,D1,D0}:
  - `pmem_wdata` sequence D0,D1,D2,D3.
  - Sequence holds when `pmem_resp` is delayed 3 cycles between beats.
  - `ch_resp`=10 once.
- Both channels request continuously from reset:
  - Grants alternate 0,1,0,1.
  - Each `ch_resp` is one cycle, with one IDLE between transactions.
- `NUM_CH`=4, all requesting, `last`=2: grant order 3,0,1,2.
- Assert `rst`=0 during beat 2 of a read:
  - Strobes drop asynchronously; no `ch_resp`.
  - After release, a pending channel-1 request is re-served from beat 0 with channel 0 at first priority.
- Spurious `pmem_resp` in IDLE: no state change, no counter advance.
